// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the CPU run-control block: state encoding and index-width helper.
package run_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } run_state_e;

  // Width of a breakpoint index; a single breakpoint still needs a 1-bit port.
  function automatic int bkpt_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/run_ctrl_bkpt_unit.sv
// PC breakpoint register file with parallel comparators and a lowest-index priority encoder.
module run_ctrl_bkpt_unit
  import run_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int N_BKPT = 2,
  parameter int IDX_W  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_bkpt_wr,
  input  logic [IDX_W-1:0] i_bkpt_idx,
  input  logic [XLEN-1:0]  i_bkpt_addr,
  input  logic             i_bkpt_valid,
  output logic             o_match,
  output logic [IDX_W-1:0] o_idx
);

  logic [N_BKPT-1:0] valid_r;
  logic [XLEN-1:0]   addr_r [N_BKPT];
  logic [N_BKPT-1:0] hit_s;
  logic [IDX_W-1:0]  idx_s;

  // Breakpoint entries; out-of-range indices match no entry and are dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_r <= {N_BKPT{1'b0}};
      for (int i = 0; i < N_BKPT; i++) begin
        addr_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_BKPT; i++) begin
        if (i_bkpt_wr && (i_bkpt_idx == IDX_W'(i))) begin
          valid_r[i] <= i_bkpt_valid;
          addr_r[i]  <= i_bkpt_addr;
        end
      end
    end
  end

  // Parallel compare, then scan downwards so the lowest matching index wins.
  always_comb begin
    hit_s = {N_BKPT{1'b0}};
    idx_s = {IDX_W{1'b0}};
    for (int i = 0; i < N_BKPT; i++) begin
      hit_s[i] = valid_r[i] && (i_pc == addr_r[i]);
    end
    for (int i = N_BKPT - 1; i >= 0; i--) begin
      idx_s = hit_s[i] ? IDX_W'(i) : idx_s;
    end
  end

  assign o_match = |hit_s;
  assign o_idx   = idx_s;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step control driving the single-cycle core's clock-enable and reset.
// Breakpoint hardware is built only when RUN_CTRL_BKPT_EN is defined.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int  XLEN   = 32,
  parameter int  N_BKPT = 2,
  parameter int  STEP_W = 8,
  parameter int  CNT_W  = 32,
  localparam int IDX_W  = bkpt_idx_w(N_BKPT)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_run_btn_d_s_o,
  input  logic               i_step_btn_d_s_o,
  input  logic               i_core_rst_req,
  input  logic [STEP_W-1:0]  i_step_count,
  input  logic [XLEN-1:0]    i_pc,
  input  logic               i_bkpt_wr,
  input  logic [IDX_W-1:0]   i_bkpt_idx,
  input  logic [XLEN-1:0]    i_bkpt_addr,
  input  logic               i_bkpt_valid,
  output logic               o_core_clk_en,
  output logic               o_core_rst,
  output logic [STATE_W-1:0] o_state,
  output logic               o_bkpt_hit,
  output logic [IDX_W-1:0]   o_bkpt_id,
  output logic [CNT_W-1:0]   o_retired
);

  run_state_e        state_r;
  run_state_e        state_nxt_s;
  logic [STEP_W-1:0] step_cnt_r;
  logic [CNT_W-1:0]  retired_r;
  logic              core_rst_r;
  logic              active_s;
  logic              clk_en_s;
  logic              bk_stop_s;

`ifdef RUN_CTRL_BKPT_EN
  logic             match_s;
  logic [IDX_W-1:0] match_idx_s;
  logic             skip_r;
  logic             hit_r;
  logic [IDX_W-1:0] id_r;

  run_ctrl_bkpt_unit #(
    .XLEN   (XLEN),
    .N_BKPT (N_BKPT),
    .IDX_W  (IDX_W)
  ) u_bkpt (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_pc         (i_pc),
    .i_bkpt_wr    (i_bkpt_wr),
    .i_bkpt_idx   (i_bkpt_idx),
    .i_bkpt_addr  (i_bkpt_addr),
    .i_bkpt_valid (i_bkpt_valid),
    .o_match      (match_s),
    .o_idx        (match_idx_s)
  );

  // skip_r lets the first cycle after resuming from HALT step off a breakpoint PC.
  assign bk_stop_s = match_s && !skip_r;

  // Breakpoint bookkeeping: skip-once flag, hit pulse and latched index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      skip_r <= 1'b0;
      hit_r  <= 1'b0;
      id_r   <= {IDX_W{1'b0}};
    end else begin
      skip_r <= (state_r == ST_HALT) &&
                ((state_nxt_s == ST_RUN) || (state_nxt_s == ST_STEP));
      hit_r  <= active_s && bk_stop_s && !i_core_rst_req;
      if (active_s && bk_stop_s && !i_core_rst_req) begin
        id_r <= match_idx_s;
      end
    end
  end

  assign o_bkpt_hit = hit_r;
  assign o_bkpt_id  = id_r;
`else
  logic unused_bkpt_s;
  assign unused_bkpt_s = ^{i_bkpt_wr, i_bkpt_idx, i_bkpt_addr, i_bkpt_valid, i_pc};
  assign bk_stop_s     = 1'b0;
  assign o_bkpt_hit    = 1'b0;
  assign o_bkpt_id     = {IDX_W{1'b0}};
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: core reset request first, then run over step.
  always_comb begin
    state_nxt_s = state_r;
    if (i_core_rst_req) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_run_btn_d_s_o)       state_nxt_s = ST_RUN;
          else if (i_step_btn_d_s_o) state_nxt_s = ST_STEP;
          else                       state_nxt_s = ST_IDLE;
        end
        ST_RUN: begin
          if (i_run_btn_d_s_o || bk_stop_s) state_nxt_s = ST_HALT;
          else                              state_nxt_s = ST_RUN;
        end
        ST_STEP: begin
          if (i_run_btn_d_s_o || bk_stop_s || (step_cnt_r == STEP_W'(1))) state_nxt_s = ST_HALT;
          else                                                            state_nxt_s = ST_STEP;
        end
        ST_HALT: begin
          if (i_run_btn_d_s_o)       state_nxt_s = ST_RUN;
          else if (i_step_btn_d_s_o) state_nxt_s = ST_STEP;
          else                       state_nxt_s = ST_HALT;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Output decode: the core only advances while running and not parked on a breakpoint.
  always_comb begin
    active_s = (state_r == ST_RUN) || (state_r == ST_STEP);
    clk_en_s = active_s && !bk_stop_s;
  end

  // Step counter, retired counter and the registered core reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      step_cnt_r <= {STEP_W{1'b0}};
      retired_r  <= {CNT_W{1'b0}};
      core_rst_r <= 1'b1;
    end else begin
      core_rst_r <= (state_nxt_s == ST_IDLE);
      if ((state_nxt_s == ST_STEP) && (state_r != ST_STEP)) begin
        step_cnt_r <= (i_step_count == {STEP_W{1'b0}}) ? STEP_W'(1) : i_step_count;
      end else if ((state_r == ST_STEP) && clk_en_s) begin
        step_cnt_r <= step_cnt_r - STEP_W'(1);
      end
      if (state_nxt_s == ST_IDLE) begin
        retired_r <= {CNT_W{1'b0}};
      end else if (clk_en_s) begin
        retired_r <= retired_r + CNT_W'(1);
      end
    end
  end

  assign o_core_clk_en = clk_en_s;
  assign o_core_rst    = core_rst_r;
  assign o_state       = state_r;
  assign o_retired     = retired_r;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: behavioural model plus directed scenarios.
// Breakpoint expectations follow RUN_CTRL_BKPT_EN.
module tb_cpu_run_ctrl;

  localparam int NB = 2;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_HALT = 2'd3;
`ifdef RUN_CTRL_BKPT_EN
  localparam bit BK_EN = 1'b1;
`else
  localparam bit BK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0, step = 1'b0, rst_req = 1'b0;
  logic [7:0]  step_count = 8'd0;
  logic [31:0] pc;
  logic        bkpt_wr = 1'b0, bkpt_valid = 1'b0;
  logic [0:0]  bkpt_idx = 1'b0;
  logic [31:0] bkpt_addr = 32'd0;
  logic        o_core_clk_en, o_core_rst, o_bkpt_hit;
  logic [1:0]  o_state;
  logic [0:0]  o_bkpt_id;
  logic [31:0] o_retired;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [1:0]  m_state;
  int          m_left;
  bit          m_skip, m_hit;
  logic [0:0]  m_id;
  logic [31:0] m_ret;
  bit          bk_v [NB];
  logic [31:0] bk_a [NB];

  cpu_run_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_run_btn_d_s_o(run), .i_step_btn_d_s_o(step), .i_core_rst_req(rst_req),
    .i_step_count(step_count), .i_pc(pc),
    .i_bkpt_wr(bkpt_wr), .i_bkpt_idx(bkpt_idx), .i_bkpt_addr(bkpt_addr), .i_bkpt_valid(bkpt_valid),
    .o_core_clk_en(o_core_clk_en), .o_core_rst(o_core_rst), .o_state(o_state),
    .o_bkpt_hit(o_bkpt_hit), .o_bkpt_id(o_bkpt_id), .o_retired(o_retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int low_match();
    for (int i = 0; i < NB; i++) if (bk_v[i] && bk_a[i] == pc) return i;
    return -1;
  endfunction

  function automatic bit m_active();
    return (m_state == S_RUN) || (m_state == S_STEP);
  endfunction

  function automatic bit m_stop();
    return BK_EN && m_active() && !m_skip && (low_match() >= 0);
  endfunction

  // Behavioural model of the controller plus a toy datapath PC (+4 per enabled cycle).
  always @(posedge clk or negedge rst_n) begin : model
    logic [1:0] nst;
    int nleft;
    bit stop, en;
    if (!rst_n) begin
      m_state <= S_IDLE; m_left <= 0; m_skip <= 1'b0; m_hit <= 1'b0;
      m_id <= 1'b0; m_ret <= 32'd0; pc <= 32'd0;
      for (int i = 0; i < NB; i++) begin bk_v[i] <= 1'b0; bk_a[i] <= 32'd0; end
    end else begin
      stop = m_stop();
      en = m_active() && !stop;
      nst = m_state;
      nleft = m_left;
      if (rst_req) nst = S_IDLE;
      else begin
        case (m_state)
          S_IDLE, S_HALT: if (run) nst = S_RUN; else if (step) nst = S_STEP;
          S_RUN: if (run || stop) nst = S_HALT;
          default: begin
            if (run || stop || m_left <= 1) nst = S_HALT;
            else nleft = m_left - 1;
          end
        endcase
      end
      if (nst == S_STEP && m_state != S_STEP) nleft = (step_count == 8'd0) ? 1 : int'(step_count);
      m_left  <= nleft;
      m_state <= nst;
      m_ret   <= (nst == S_IDLE) ? 32'd0 : m_ret + (en ? 32'd1 : 32'd0);
      m_hit   <= stop && !rst_req;
      if (stop && !rst_req) m_id <= 1'(low_match());
      m_skip  <= (m_state == S_HALT) && (nst == S_RUN || nst == S_STEP);
      pc      <= (m_state == S_IDLE) ? 32'd0 : (en ? pc + 32'd4 : pc);
      if (bkpt_wr && int'(bkpt_idx) < NB) begin
        bk_v[bkpt_idx] <= bkpt_valid;
        bk_a[bkpt_idx] <= bkpt_addr;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("state", o_state, m_state);
      check("core_rst", o_core_rst, m_state == S_IDLE);
      check("clk_en", o_core_clk_en, m_active() && !m_stop());
      check("retired", o_retired, m_ret);
      check("bkpt_hit", o_bkpt_hit, m_hit);
      check("bkpt_id", o_bkpt_id, m_id);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit r, input bit s);
    run = r; step = s;
    tick();
    run = 1'b0; step = 1'b0;
  endtask

  task automatic bk_write(input int idx, input logic [31:0] a, input bit v);
    bkpt_wr = 1'b1; bkpt_idx = 1'(idx); bkpt_addr = a; bkpt_valid = v;
    tick();
    bkpt_wr = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk_en = 1'b1;
    check("rst_state", o_state, 2'b00);
    check("rst_core_rst", o_core_rst, 1'b1);
    check("rst_clk_en", o_core_clk_en, 1'b0);
    check("rst_retired", o_retired, 32'd0);
    rst_n = 1'b1;
    tick();

    // Run, free-run 10 cycles, halt
    pulse(1'b1, 1'b0);
    check("run_core_rst", o_core_rst, 1'b0);
    check("run_clk_en", o_core_clk_en, 1'b1);
    repeat (10) tick();
    check("run_retired10", o_retired, 32'd10);
    pulse(1'b1, 1'b0);
    check("halt_state", o_state, 2'b11);
    check("halt_clk_en", o_core_clk_en, 1'b0);
    check("halt_retired", o_retired, 32'd11);

    // Step bursts of 3 and of 0 (treated as 1)
    step_count = 8'd3;
    pulse(1'b0, 1'b1);
    repeat (3) tick();
    check("step3_state", o_state, 2'b11);
    check("step3_retired", o_retired, 32'd14);
    step_count = 8'd0;
    pulse(1'b0, 1'b1);
    tick();
    check("step0_state", o_state, 2'b11);
    check("step0_retired", o_retired, 32'd15);

    // Back to IDLE so the PC restarts from 0, then arm breakpoint 1 at 0x10
    rst_req = 1'b1; tick(); rst_req = 1'b0;
    check("req_idle", o_state, 2'b00);
    bk_write(1, 32'h10, 1'b1);
    pulse(1'b1, 1'b0);
    repeat (4) tick();
    check("pc_at_bkpt", pc, 32'h10);
`ifdef RUN_CTRL_BKPT_EN
    check("bkpt_clk_en", o_core_clk_en, 1'b0);
    tick();
    check("bkpt_halt", o_state, 2'b11);
    check("bkpt_hit", o_bkpt_hit, 1'b1);
    check("bkpt_id1", o_bkpt_id, 1'b1);
    check("bkpt_retired", o_retired, 32'd4);
    pulse(1'b1, 1'b0);
    check("resume_clk_en", o_core_clk_en, 1'b1);
    tick();
    check("resume_state", o_state, 2'b01);
    check("resume_no_hit", o_bkpt_hit, 1'b0);
    check("resume_retired", o_retired, 32'd5);
`else
    check("nobk_clk_en", o_core_clk_en, 1'b1);
    tick();
    check("nobk_state", o_state, 2'b01);
    check("nobk_hit", o_bkpt_hit, 1'b0);
    tick(); tick();
    check("nobk_retired", o_retired, 32'd7);
`endif
    pulse(1'b1, 1'b0);

    // Two breakpoints at the same PC: lowest index reported
    bk_write(0, 32'h20, 1'b1);
    bk_write(1, 32'h20, 1'b1);
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 20 && !o_bkpt_hit; i++) tick();
`ifdef RUN_CTRL_BKPT_EN
    check("dual_hit", o_bkpt_hit, 1'b1);
    check("dual_id0", o_bkpt_id, 1'b0);
`endif
    if (m_state == S_RUN) pulse(1'b1, 1'b0);
    bk_write(0, 32'h0, 1'b0);
    bk_write(1, 32'h0, 1'b0);

    // Run and step together from HALT: run wins
    check("pre_both_halt", o_state, 2'b11);
    pulse(1'b1, 1'b1);
    check("both_run", o_state, 2'b01);
    pulse(1'b1, 1'b0);

    // Core reset request mid-step
    step_count = 8'd5;
    pulse(1'b0, 1'b1);
    tick(); tick();
    check("mid_step", o_state, 2'b10);
    rst_req = 1'b1; tick(); rst_req = 1'b0;
    check("req_state", o_state, 2'b00);
    check("req_core_rst", o_core_rst, 1'b1);
    check("req_retired", o_retired, 32'd0);
    check("req_clk_en", o_core_clk_en, 1'b0);

    // Asynchronous reset pulse mid-run
    pulse(1'b1, 1'b0);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", o_state, 2'b00);
    check("arst_core_rst", o_core_rst, 1'b1);
    check("arst_clk_en", o_core_clk_en, 1'b0);
    check("arst_retired", o_retired, 32'd0);
    check("arst_hit", o_bkpt_hit, 1'b0);
    check("arst_id", o_bkpt_id, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
